dice_cgra_cfg_loader: RTL and testbench

//  Streams the static CGRA bitstream (NUM_TILES x TILE_CFG_W bits) in over a WORD_W-bit

---
 rtl/dice_cgra_cfg_loader_if.sv | 14 +
 rtl/dice_cgra_cfg_loader.sv | 119 +++++++++++
 tb/tb_dice_cgra_cfg_loader.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dice_cgra_cfg_loader_if.sv
// Config word stream between the config-fetch logic and the CGRA config loader.
//   cfg_in_valid  master->slave  word on cfg_in_data is valid
//   cfg_in_data   master->slave  config word, LSB-first packing
//   cfg_in_ready  slave->master  loader accepts a word this cycle
interface dice_cgra_cfg_loader_if #(
  parameter int unsigned WORD_W = 32
);
  logic              cfg_in_valid;
  logic [WORD_W-1:0] cfg_in_data;
  logic              cfg_in_ready;

  modport master (output cfg_in_valid, output cfg_in_data, input cfg_in_ready);
  modport slave  (input cfg_in_valid, input cfg_in_data, output cfg_in_ready);
endinterface

// File: rtl/dice_cgra_cfg_loader.sv
// Streams the static CGRA bitstream in word by word, assembles it in a shadow
// register and commits the whole image atomically to cgra_cfg while the array
// is idle, so tiles never observe a partial configuration.
//   clk, rst          clock and synchronous active-high reset
//   cfg_start         pulse: begin a new load (honoured in IDLE only)
//   cfg_abort         discard the load in progress
//   cfg_in            word stream (slave side): valid/data in, ready out
//   cgra_idle         array not executing; commit permitted
//   cgra_cfg          active configuration, tile t at [t*TILE_CFG_W +: TILE_CFG_W]
//   cfg_busy          loader not in IDLE
//   cfg_done          one-cycle pulse in the cycle after the commit edge
//   cfg_words_loaded  words accepted in the current load
module dice_cgra_cfg_loader #(
  parameter int unsigned TILE_CFG_W = 156,
  parameter int unsigned NUM_TILES  = 16,
  parameter int unsigned WORD_W     = 32,
  localparam int unsigned CFG_W     = NUM_TILES * TILE_CFG_W,
  localparam int unsigned WORDS     = (CFG_W + WORD_W - 1) / WORD_W,
  localparam int unsigned CNT_W     = $clog2(WORDS + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_start,
  input  logic                         cfg_abort,
  dice_cgra_cfg_loader_if.slave        cfg_in,
  input  logic                         cgra_idle,
  output logic [CFG_W-1:0]             cgra_cfg,
  output logic                         cfg_busy,
  output logic                         cfg_done,
  output logic [CNT_W-1:0]             cfg_words_loaded
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_COMMIT
  } state_t;

  state_t state_q, state_d;

  // Shadow is word-addressed; any bits of the last word above CFG_W are
  // simply never copied into cgra_cfg.
  logic [WORDS-1:0][WORD_W-1:0] shadow;
  logic [WORDS*WORD_W-1:0]      shadow_flat;
  logic [CNT_W-1:0]             count;

  logic ready;
  logic accept;
  logic commit;
  logic clr_count;

  assign shadow_flat = shadow;

  always_comb begin
    state_d   = state_q;
    ready     = 1'b0;
    accept    = 1'b0;
    commit    = 1'b0;
    clr_count = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_start && !cfg_abort) begin
          state_d   = LOAD;
          clr_count = 1'b1;
        end
      end
      LOAD: begin
        // Abort masks ready, so it always beats a same-cycle handshake.
        if (cfg_abort) begin
          state_d   = IDLE;
          clr_count = 1'b1;
        end else begin
          ready = 1'b1;
          if (cfg_in.cfg_in_valid) begin
            accept = 1'b1;
            if (count == LAST_IDX) state_d = WAIT_COMMIT;
          end
        end
      end
      WAIT_COMMIT: begin
        if (cfg_abort) begin
          state_d   = IDLE;
          clr_count = 1'b1;
        end else if (cgra_idle) begin
          commit  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shadow   <= '0;
      count    <= '0;
      cgra_cfg <= '0;
      cfg_done <= 1'b0;
    end else begin
      state_q  <= state_d;
      cfg_done <= commit;
      if (accept) shadow[count] <= cfg_in.cfg_in_data;
      if (clr_count) begin
        count <= '0;
      end else if (accept) begin
        count <= count + CNT_W'(1);
      end
      if (commit) cgra_cfg <= shadow_flat[CFG_W-1:0];
    end
  end

  assign cfg_in.cfg_in_ready = ready;
  assign cfg_busy            = (state_q != IDLE);
  assign cfg_words_loaded    = count;

endmodule

// File: tb/tb_dice_cgra_cfg_loader.sv
module tb_dice_cgra_cfg_loader;

  localparam int WORDS = 78;
  localparam int CFG_W = 2496;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_start;
  logic             cfg_abort;
  logic             cgra_idle;
  logic [CFG_W-1:0] cgra_cfg;
  logic             cfg_busy;
  logic             cfg_done;
  logic [6:0]       cfg_words_loaded;

  dice_cgra_cfg_loader_if #(.WORD_W(32)) cfg_in ();

  dice_cgra_cfg_loader #(
    .TILE_CFG_W(156),
    .NUM_TILES (16),
    .WORD_W    (32)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_start       (cfg_start),
    .cfg_abort       (cfg_abort),
    .cfg_in          (cfg_in),
    .cgra_idle       (cgra_idle),
    .cgra_cfg        (cgra_cfg),
    .cfg_busy        (cfg_busy),
    .cfg_done        (cfg_done),
    .cfg_words_loaded(cfg_words_loaded)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  // Reference model: the image the array should currently be running.
  logic [31:0] active [WORDS];

  always @(negedge clk) if (cfg_done === 1'b1) done_cnt++;

  typedef struct {
    int pat;        // 0: k+1, 1: 0xA5A5_0000+k, 2: random
    bit gaps;       // random idle cycles between words
    int idle_wait;  // cycles cgra_idle is held low after the last word
    int abort_at;   // -1 none; <WORDS abort in LOAD after that many words; WORDS abort in WAIT_COMMIT
    int start_at;   // word index at which a stray cfg_start is pulsed, -1 none
    bit exp_commit; // expected number of cfg_done pulses for the run
  } scen_t;

  scen_t tbl [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_img(input string name, input logic [31:0] exp [WORDS]);
    int bad;
    bad = -1;
    checks++;
    for (int k = WORDS - 1; k >= 0; k--)
      if (cgra_cfg[k*32 +: 32] !== exp[k]) bad = k;
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s: word %0d got %h expected %h", name, bad, cgra_cfg[bad*32 +: 32], exp[bad]);
    end
  endtask

  task automatic run_load(input scen_t s);
    logic [31:0] img [WORDS];
    int d0;
    bit aborted;
    d0 = done_cnt;
    aborted = 1'b0;
    for (int k = 0; k < WORDS; k++)
      img[k] = (s.pat == 0) ? 32'(k + 1) : (s.pat == 1) ? 32'hA5A5_0000 + 32'(k) : $urandom();

    cgra_idle = (s.idle_wait == 0 && s.abort_at != WORDS);
    cfg_start = 1'b1;
    #1;
    chk("ready_idle", cfg_in.cfg_in_ready, 1'b0);
    tick();
    cfg_start = 1'b0;
    chk("busy_start", cfg_busy, 1'b1);
    chk("count_start", cfg_words_loaded, 0);

    for (int k = 0; k < WORDS; k++) begin
      if (s.abort_at == k) begin
        aborted = 1'b1;
        break;
      end
      if (s.gaps) begin
        repeat ($urandom_range(0, 2)) begin
          cfg_in.cfg_in_valid = 1'b0;
          tick();
        end
      end
      cfg_in.cfg_in_valid = 1'b1;
      cfg_in.cfg_in_data  = img[k];
      cfg_start = (k == s.start_at);
      #1;
      chk("ready_load", cfg_in.cfg_in_ready, 1'b1);
      chk("count_load", cfg_words_loaded, 64'(k));
      tick();
      cfg_start = 1'b0;
    end

    if (aborted) begin
      cfg_in.cfg_in_valid = 1'b1;
      cfg_in.cfg_in_data  = 32'hBAD0_BAD0;
      cfg_abort = 1'b1;
      #1;
      chk("ready_abort", cfg_in.cfg_in_ready, 1'b0);
      tick();
      cfg_abort = 1'b0;
      cfg_in.cfg_in_valid = 1'b0;
      chk("busy_abort", cfg_busy, 1'b0);
      chk("count_abort", cfg_words_loaded, 0);
      chk_img("img_abort", active);
      tick();
    end else begin
      // Valid stays high through the wait: no extra word may be taken.
      cfg_in.cfg_in_valid = 1'b1;
      cfg_in.cfg_in_data  = 32'hDEAD_BEEF;
      #1;
      chk("ready_wait", cfg_in.cfg_in_ready, 1'b0);
      chk("busy_wait", cfg_busy, 1'b1);
      chk("count_wait", cfg_words_loaded, 64'(WORDS));
      chk("done_wait", cfg_done, 1'b0);
      for (int i = 0; i < s.idle_wait; i++) begin
        tick();
        chk("busy_hold", cfg_busy, 1'b1);
        chk("ready_hold", cfg_in.cfg_in_ready, 1'b0);
        chk("count_hold", cfg_words_loaded, 64'(WORDS));
        chk_img("img_hold", active);
      end
      if (s.abort_at == WORDS) begin
        cfg_abort = 1'b1;
        cgra_idle = 1'b1;
        tick();
        cfg_abort = 1'b0;
        chk("busy_wabort", cfg_busy, 1'b0);
        chk("count_wabort", cfg_words_loaded, 0);
        chk("done_wabort", cfg_done, 1'b0);
        chk_img("img_wabort", active);
        tick();
      end else begin
        cgra_idle = 1'b1;
        tick();
        chk("done_commit", cfg_done, 1'b1);
        chk("busy_commit", cfg_busy, 1'b0);
        chk_img("img_commit", img);
        active = img;
        tick();
        chk("done_pulse", cfg_done, 1'b0);
      end
      cfg_in.cfg_in_valid = 1'b0;
    end
    chk("done_count", done_cnt - d0, 64'(s.exp_commit));
  endtask

  initial begin
    logic [159:0] t0;
    int d0;
    rst = 1'b1;
    cfg_start = 1'b0;
    cfg_abort = 1'b0;
    cgra_idle = 1'b0;
    cfg_in.cfg_in_valid = 1'b0;
    cfg_in.cfg_in_data  = '0;
    for (int k = 0; k < WORDS; k++) active[k] = '0;

    repeat (2) tick();
    chk("rst_busy", cfg_busy, 1'b0);
    chk("rst_done", cfg_done, 1'b0);
    rst = 1'b0;
    tick();
    chk_img("rst_img", active);
    chk("rst_ready", cfg_in.cfg_in_ready, 1'b0);
    chk("rst_count", cfg_words_loaded, 0);

    // Start and abort together in IDLE: abort wins.
    cfg_start = 1'b1;
    cfg_abort = 1'b1;
    tick();
    cfg_start = 1'b0;
    cfg_abort = 1'b0;
    chk("start_abort_busy", cfg_busy, 1'b0);
    tick();
    chk("start_abort_busy2", cfg_busy, 1'b0);

    tbl[0] = '{0, 1'b0, 0,  -1,    -1, 1'b1};
    tbl[1] = '{0, 1'b1, 10, -1,    -1, 1'b1};
    tbl[2] = '{2, 1'b0, 0,  40,    -1, 1'b0};
    tbl[3] = '{2, 1'b1, 3,  WORDS, -1, 1'b0};
    tbl[4] = '{1, 1'b0, 0,  -1,    -1, 1'b1};
    tbl[5] = '{2, 1'b1, 4,  -1,    20, 1'b1};
    for (int r = 6; r < 10; r++) begin
      int sel;
      sel = $urandom_range(0, 3);
      tbl[r].pat       = 2;
      tbl[r].gaps      = 1'($urandom_range(0, 1));
      tbl[r].idle_wait = $urandom_range(0, 5);
      tbl[r].abort_at  = (sel < 2) ? -1 : (sel == 2) ? $urandom_range(0, WORDS - 1) : WORDS;
      tbl[r].start_at  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, WORDS - 1) : -1;
      tbl[r].exp_commit = (tbl[r].abort_at < 0);
    end

    for (int r = 0; r < 10; r++) begin
      run_load(tbl[r]);
      if (r == 0) begin
        t0 = {active[4], active[3], active[2], active[1], active[0]};
        checks++;
        if (cgra_cfg[155:0] !== t0[155:0]) begin
          failures++;
          $display("FAIL tile0: got %h expected %h", cgra_cfg[155:0], t0[155:0]);
        end
      end
    end

    // Reset in the middle of a load.
    d0 = done_cnt;
    cgra_idle = 1'b1;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    for (int k = 0; k < 50; k++) begin
      cfg_in.cfg_in_valid = 1'b1;
      cfg_in.cfg_in_data  = $urandom();
      tick();
    end
    chk("mid_count", cfg_words_loaded, 50);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cfg_in.cfg_in_valid = 1'b0;
    for (int k = 0; k < WORDS; k++) active[k] = '0;
    chk_img("mid_rst_img", active);
    chk("mid_rst_busy", cfg_busy, 1'b0);
    chk("mid_rst_count", cfg_words_loaded, 0);
    tick();
    chk("mid_rst_done", done_cnt - d0, 0);
    run_load('{2, 1'b1, 2, -1, -1, 1'b1});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
